imm_extend_stage: RTL and testbench
===================================

# imm_extend_stage

Registered, parametrised immediate-extension stage for the CPU decode path. It selects one of four configurable immediate field widths from the MSBs of the instruction immediate field. It sign- or zero-extends the field to the datapath width and optionally scales it by a left shift. Results are buffered in a 2-entry skid buffer with valid/ready handshakes on both sides, so decode and execute can stall independently.

## Interface
- IN_W, 27, width of raw immediate field from the instruction
- OUT_W, 32, datapath width of extended result
- W0, 15, field width for sel=0 (taken from inme_in[IN_W-1 -: W0])
- W1, 19, field width for sel=1
- W2, 23, field width for sel=2
- W3, 27, field width for sel=3
- SH_W, 3, width of shamt (shift 0..2^SH_W-1)
- Legal values: 1 ≤ Wi ≤ IN_W; Wi ≤ OUT_W. Violations are elaboration errors.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of buffered entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- inme_in  in  IN_W  raw immediate bits
- sel  in  2  field-width select
- zext  in  1  1 = zero-extend, 0 = sign-extend
- shamt  in  SH_W  left-shift amount (scaling)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- inme_out  out  OUT_W  extended, shifted immediate
- ovf  out  1  shift discarded significant bits

## Operation
- Field: f = inme_in[IN_W-1 -: Wsel].
- Extension: fill with f[MSB] if zext=0, else 0, giving an OUT_W-bit value e.
- Result: inme_out = e << shamt, truncated to OUT_W.
- ovf, sign mode: set if any bit shifted out, or the new MSB, differs from e[OUT_W-1].
- ovf, zero mode: set if any shifted-out bit is 1.
- Computation is done on the input side. Buffered entries hold {inme_out, ovf}.
- Skid buffer FSM:
  - States: EMPTY, ONE, TWO.
  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
  - EMPTY: accept → ONE.
  - ONE:
    - accept & !drain → TWO
    - drain & !accept → EMPTY
    - accept & drain → ONE (new entry replaces the head)
  - TWO:
    - drain → ONE. Accept is impossible here.
- in_ready = (state != TWO). This is decoded from the state register only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). inme_out/ovf always show the head entry (oldest first, FIFO order).
- Flush has priority over everything. Next state is EMPTY, and any same-cycle accept is discarded.
- Outputs while EMPTY hold their last value. They are don't-care to consumers.

## Timing
- Latency: an entry accepted at edge N is visible on inme_out with out_valid=1 after edge N (same cycle as N+1 sampling).
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Reset (async assert, sync-safe deassert by the system):
  - state = EMPTY
  - out_valid = 0, in_ready = 1
  - inme_out = 0, ovf = 0
- Reset mid-transfer discards all entries immediately, with no output glitch to valid.
- Flush at edge N: out_valid = 0 and in_ready = 1 after N.
- Data outputs are registered. Critical path is extend + barrel shift on the input side.

## Configuration
- IMMX_SHIFT_EN defined: shamt and the ovf logic are implemented as above.
- IMMX_SHIFT_EN undefined:
  - shamt is ignored, so the result is the plain extension e.
  - ovf is tied to 0 and no shifter is synthesised.
  - Port list is unchanged.

## Test plan
- Sign/zero extension: sel=0, inme_in=27'h4000000, shamt=0.
  - zext=0 → inme_out=32'hFFFFC000, ovf=0.
  - zext=1 → inme_out=32'h00004000.
- Widest field with shift: sel=3, inme_in=27'h0000123, zext=0, shamt=2 → inme_out=32'h0000048C, ovf=0. Without IMMX_SHIFT_EN → 32'h00000123.
- Overflow: sel=3, inme_in=27'h2000000, zext=0, shamt=7 → inme_out=32'h00000000, ovf=1.
- Backpressure: out_ready=0, push A, B, C on consecutive cycles.
  - in_ready drops after B is accepted, and C is held upstream.
  - Raise out_ready: outputs appear as A, B, C on consecutive cycles, none lost or duplicated.
- Flush with state TWO and a simultaneous in_valid=1 → next cycle out_valid=0, in_ready=1. The flushed entries and the same-cycle input never appear.
- Assert rst_n=0 asynchronously mid-stream with state ONE → out_valid, inme_out and ovf go to 0 before the next clock edge, and in_ready goes to 1.

Source files
------------

// File: rtl/imm_extend_stage.sv
// Immediate extension stage: field select, sign/zero extend, optional scaling shift
// (enabled by `define IMMX_SHIFT_EN), results buffered in a 2-entry skid buffer.
module imm_extend_stage #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 32,
    parameter int W0    = 15,
    parameter int W1    = 19,
    parameter int W2    = 23,
    parameter int W3    = 27,
    parameter int SH_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  inme_in,
    input  logic [1:0]       sel,
    input  logic             zext,
    input  logic [SH_W-1:0]  shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] inme_out,
    output logic             ovf
);

    if (W0 < 1 || W0 > IN_W || W0 > OUT_W) begin : g_bad_w0
        $error("imm_extend_stage: illegal W0");
    end
    if (W1 < 1 || W1 > IN_W || W1 > OUT_W) begin : g_bad_w1
        $error("imm_extend_stage: illegal W1");
    end
    if (W2 < 1 || W2 > IN_W || W2 > OUT_W) begin : g_bad_w2
        $error("imm_extend_stage: illegal W2");
    end
    if (W3 < 1 || W3 > IN_W || W3 > OUT_W) begin : g_bad_w3
        $error("imm_extend_stage: illegal W3");
    end

    localparam logic [OUT_W-1:0] ONE  = OUT_W'(1);
    localparam logic [OUT_W-1:0] ALL1 = {OUT_W{1'b1}};

    typedef enum logic [1:0] {EMPTY, ONE_E, TWO} state_t;

    function automatic logic [OUT_W-1:0] extend_field(input logic [IN_W-1:0] raw,
                                                      input int w, input logic z);
        logic [OUT_W-1:0] f;
        logic             s;
        f = OUT_W'(raw >> (IN_W - w));
        s = |(f & (ONE << (w - 1)));
        return (s && !z) ? (f | (ALL1 << w)) : f;
    endfunction

`ifdef IMMX_SHIFT_EN
    // Shift with the fill replicated above the result; ovf flags any loss of value.
    function automatic logic [OUT_W:0] scale(input logic [OUT_W-1:0] e,
                                             input logic [SH_W-1:0] sh, input logic z);
        logic [2*OUT_W-1:0] wide;
        logic               pad;
        logic               o;
        pad  = ~z & e[OUT_W-1];
        wide = {{OUT_W{pad}}, e} << sh;
        o    = (wide[2*OUT_W-1:OUT_W] != {OUT_W{pad}});
        if (!z) o = o | (wide[OUT_W-1] != pad);
        return {o, wide[OUT_W-1:0]};
    endfunction
`endif

    state_t           state, state_nxt;
    logic             accept, drain;
    logic             load_head_new, load_head_tail, load_tail;
    logic [OUT_W-1:0] ext_p0, res_p0;
    logic             ovf_p0;
    logic [OUT_W-1:0] head_data_p1, tail_data_p1;
    logic             head_ovf_p1, tail_ovf_p1;

    // Stage p0: combinational extend and scale on the input side
    always_comb begin
        ext_p0 = '0;
        case (sel)
            2'd0:    ext_p0 = extend_field(inme_in, W0, zext);
            2'd1:    ext_p0 = extend_field(inme_in, W1, zext);
            2'd2:    ext_p0 = extend_field(inme_in, W2, zext);
            default: ext_p0 = extend_field(inme_in, W3, zext);
        endcase
    end

`ifdef IMMX_SHIFT_EN
    assign {ovf_p0, res_p0} = scale(ext_p0, shamt, zext);
`else
    logic unused_shamt;
    assign unused_shamt = ^shamt;
    assign res_p0       = ext_p0;
    assign ovf_p0       = 1'b0;
`endif

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_head_new  = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nxt     = ONE_E;
                    load_head_new = 1'b1;
                end
                ONE_E: if (accept && drain) begin
                    load_head_new = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                    load_tail = 1'b1;
                end else if (drain) begin
                    state_nxt = EMPTY;
                end
                TWO: if (drain) begin
                    state_nxt      = ONE_E;
                    load_head_tail = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Stage p1: buffered entries; the head drives the outputs directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data_p1 <= '0;
            head_ovf_p1  <= 1'b0;
        end else if (load_head_new) begin
            head_data_p1 <= res_p0;
            head_ovf_p1  <= ovf_p0;
        end else if (load_head_tail) begin
            head_data_p1 <= tail_data_p1;
            head_ovf_p1  <= tail_ovf_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_tail) begin
            tail_data_p1 <= res_p0;
            tail_ovf_p1  <= ovf_p0;
        end
    end

    assign inme_out = head_data_p1;
    assign ovf      = head_ovf_p1;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Randomized and directed bench for imm_extend_stage against an arithmetic FIFO model.
module tb_imm_extend_stage;
    localparam int IN_W  = 27;
    localparam int OUT_W = 32;
    localparam int SH_W  = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  inme_in = '0;
    logic [1:0]       sel = '0;
    logic             zext = 1'b0;
    logic [SH_W-1:0]  shamt = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] inme_out;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    logic [OUT_W:0] q[$];

    imm_extend_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inme_in(inme_in), .sel(sel), .zext(zext), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .inme_out(inme_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: integer value of the field, multiplied by 2**shamt, range-checked.
    function automatic logic [OUT_W:0] ref_imm(input logic [IN_W-1:0] raw, input logic [1:0] s,
                                               input logic z, input logic [SH_W-1:0] sh);
        int     w;
        longint f, v;
        logic   o;
        logic [63:0] bits;
        case (s)
            2'd0:    w = 15;
            2'd1:    w = 19;
            2'd2:    w = 23;
            default: w = 27;
        endcase
        f = longint'(raw) / (longint'(1) << (IN_W - w));
        if (!z && f >= (longint'(1) << (w - 1))) v = f - (longint'(1) << w);
        else                                     v = f;
        o = 1'b0;
`ifdef IMMX_SHIFT_EN
        v = v * (longint'(1) << sh);
        if (z) o = (v >= (longint'(1) << OUT_W));
        else   o = (v < -(longint'(1) << (OUT_W - 1))) || (v >= (longint'(1) << (OUT_W - 1)));
`endif
        bits = v;
        return {o, bits[OUT_W-1:0]};
    endfunction

    task automatic drive(input logic v, input logic [IN_W-1:0] raw, input logic [1:0] s,
                         input logic z, input logic [SH_W-1:0] sh);
        in_valid = v;
        inme_in  = raw;
        sel      = s;
        zext     = z;
        shamt    = sh;
    endtask

    task automatic step();
        bit             acc, drn;
        logic [OUT_W:0] nv;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() != 0) && out_ready;
        nv  = ref_imm(inme_in, sel, zext, shamt);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(nv);
        end
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("inme_out", inme_out, q[0][OUT_W-1:0]);
            check("ovf", ovf, q[0][OUT_W]);
        end
    endtask

    task automatic vec(input string tag, input logic [IN_W-1:0] raw, input logic [1:0] s,
                       input logic z, input logic [SH_W-1:0] sh,
                       input logic [OUT_W-1:0] exp_out, input logic exp_ovf);
        out_ready = 1'b1;
        drive(1'b1, raw, s, z, sh);
        step();
        in_valid = 1'b0;
        check({tag, "_out"}, inme_out, exp_out);
        check({tag, "_ovf"}, ovf, exp_ovf);
    endtask

    logic [OUT_W:0] ea, eb, ec;

    initial begin
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_inme_out", inme_out, 0);
        check("rst_ovf", ovf, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        vec("sext", 27'h4000000, 2'd0, 1'b0, 3'd0, 32'hFFFFC000, 1'b0);
        vec("zext", 27'h4000000, 2'd0, 1'b1, 3'd0, 32'h00004000, 1'b0);
`ifdef IMMX_SHIFT_EN
        vec("shift", 27'h0000123, 2'd3, 1'b0, 3'd2, 32'h0000048C, 1'b0);
        vec("ovfl", 27'h2000000, 2'd3, 1'b0, 3'd7, 32'h00000000, 1'b1);
`else
        vec("shift", 27'h0000123, 2'd3, 1'b0, 3'd2, 32'h00000123, 1'b0);
        vec("ovfl", 27'h2000000, 2'd3, 1'b0, 3'd7, 32'h02000000, 1'b0);
`endif
        step();

        // Backpressure: A, B accepted, C held, then drained in order
        out_ready = 1'b0;
        ea = ref_imm(27'h1111111, 2'd3, 1'b1, 3'd1);
        eb = ref_imm(27'h2222222, 2'd2, 1'b0, 3'd2);
        ec = ref_imm(27'h4444444, 2'd1, 1'b0, 3'd3);
        drive(1'b1, 27'h1111111, 2'd3, 1'b1, 3'd1);
        step();
        drive(1'b1, 27'h2222222, 2'd2, 1'b0, 3'd2);
        step();
        check("bp_in_ready_low", in_ready, 0);
        drive(1'b1, 27'h4444444, 2'd1, 1'b0, 3'd3);
        step();
        check("bp_hold", in_ready, 0);
        check("bp_a", {ovf, inme_out}, ea);
        out_ready = 1'b1;
        step();
        check("bp_b", {ovf, inme_out}, eb);
        step();
        check("bp_c", {ovf, inme_out}, ec);
        in_valid = 1'b0;
        step();
        check("bp_empty", out_valid, 0);

        // Flush from TWO with a simultaneous input
        out_ready = 1'b0;
        drive(1'b1, 27'h0ABCDEF, 2'd3, 1'b0, 3'd0);
        step();
        step();
        check("fl_full", in_ready, 0);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        step();

        // Asynchronous reset while holding one entry
        out_ready = 1'b0;
        drive(1'b1, 27'h4000000, 2'd0, 1'b0, 3'd0);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_inme_out", inme_out, 0);
        check("ar_ovf", ovf, 0);
        check("ar_in_ready", in_ready, 1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, IN_W'($urandom), 2'($urandom), 1'($urandom),
                  SH_W'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
